reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register and accumulator width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2, select width; NUM_REGS = 2**ADDR_W general registers.
REQ-003 reg_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reg_rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_sel  in  ADDR_W  write-port register select.
REQ-006 RF_we  in  1  register write enable.
REQ-007 data_in  in  DATA_W  register write data.
REQ-008 rd_sel_a / rd_sel_b  in  ADDR_W each  read-port A/B selects.
REQ-009 data_out_a / data_out_b  out  DATA_W each  read-port A/B data, combinational.
REQ-010 Acc_we  in  1  accumulator write enable.
REQ-011 Acc_in  in  DATA_W  accumulator write data.
REQ-012 Acc_out  out  DATA_W  accumulator value, driven directly from the Acc register.
REQ-013 save_req / restore_req  in  1 each  context save / restore request, level-sampled.
REQ-014 busy  out  1  high while a save or restore is in progress.
REQ-015 done  out  1  one-cycle pulse at completion of a save or restore.

Function
REQ-016 SHALL hold NUM_REGS x DATA_W working registers R[], one Acc, one shadow bank S[] of NUM_REGS entries, one shadow S_acc.
REQ-017 Write port: when in IDLE with RF_we=1, R[wr_sel] <= data_in at the clock edge; when in IDLE with Acc_we=1, Acc <= Acc_in at the clock edge; both writes SHALL be allowed in the same cycle.
REQ-018 Read ports: data_out_a = R[rd_sel_a] and data_out_b = R[rd_sel_b], zero-cycle latency; both ports may select the same register.
REQ-019 FSM states: IDLE, SAVE, RESTORE, tracked with index counter idx of ADDR_W bits.
REQ-020 IDLE with save_req=1 at an edge: go to SAVE, idx <= 0; save_req and restore_req both 1: save wins.
REQ-021 IDLE with restore_req=1 and save_req=0 at an edge: go to RESTORE, idx <= 0.
REQ-022 A register or Acc write in the same IDLE cycle as an accepted request SHALL still complete.
REQ-023 SAVE, each edge: S[idx] <= R[idx], idx <= idx+1; at idx=NUM_REGS-1 additionally S_acc <= Acc, go to IDLE, done <= 1.
REQ-024 RESTORE, each edge: R[idx] <= S[idx], idx <= idx+1; at idx=NUM_REGS-1 additionally Acc <= S_acc, go to IDLE, done <= 1.
REQ-025 busy SHALL be 1 exactly when state is not IDLE, i.e. for NUM_REGS consecutive cycles per operation.
REQ-026 done SHALL be high only in the first cycle after returning to IDLE; otherwise 0.
REQ-027 While busy, RF_we, Acc_we, save_req and restore_req SHALL be ignored; dropped writes SHALL leave no side effect.
REQ-028 Read ports SHALL remain functional while busy and reflect R[] mid-restore, one entry per cycle.
REQ-029 idx wrap from NUM_REGS-1 to 0 SHALL coincide with the return to IDLE; no extra cycle.

Reset
REQ-030 reg_rst=1 SHALL immediately clear R[], S[], Acc, S_acc, idx to 0, state to IDLE, busy and done to 0.
REQ-031 Reset during SAVE or RESTORE SHALL abort the operation with no done pulse.
REQ-032 After reset deassertion, the first accepted request or write SHALL be at the next rising edge.

Configuration
REQ-033 Macro RF_BYPASS_EN defined: a read port whose select equals wr_sel while RF_we=1 in IDLE SHALL output data_in in the same cycle (write-first).
REQ-034 RF_BYPASS_EN undefined: read ports SHALL output the stored R[] value (old data) until after the edge; no bypass logic present.

Verification
REQ-035 Reset, then write R0..R3 = 0x11,0x22,0x33,0x44 and Acc=0x5A; read A=2, B=3 -> data_out_a=0x33, data_out_b=0x44, Acc_out=0x5A.
REQ-036 save_req one cycle -> busy high 4 cycles, done pulses once; then overwrite R[]=0xFF and Acc=0x00; restore_req -> after done, R0..R3 = 0x11..0x44, Acc_out=0x5A.
REQ-037 RF_we=1 wr_sel=1 data_in=0x99 while busy -> R1 unchanged after operation ends.
REQ-038 save_req=restore_req=1 in IDLE -> SAVE performed; S[] equals R[] and R[] unchanged.
REQ-039 reg_rst asserted in cycle 2 of RESTORE -> all outputs 0, busy=0, done never pulses.
REQ-040 rd_sel_a=wr_sel=2, RF_we=1, data_in=0x77, R2=0x33 -> data_out_a=0x77 with RF_BYPASS_EN, 0x33 without.

Source files
------------

// File: rtl/reg_bank.sv
// Register file + accumulator with a shadow context; RF_BYPASS_EN adds write-first read bypass.
// Reads are combinational; save/restore copy one entry per cycle and ignore all inputs while busy.
module reg_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              reg_clk,
  input  logic              reg_rst,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic              RF_we,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              Acc_we,
  input  logic [DATA_W-1:0] Acc_in,
  output logic [DATA_W-1:0] Acc_out,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              busy,
  output logic              done
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              done_nxt;
  logic              last;

  logic [DATA_W-1:0] rf     [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] shadow_acc;

  assign last    = (idx == IDX_LAST);
  assign busy    = (state != IDLE);
  assign Acc_out = acc;

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Save takes priority when both requests arrive together.
        if (save_req) begin
          state_nxt = SAVE;
          idx_nxt   = '0;
        end else if (restore_req) begin
          state_nxt = RESTORE;
          idx_nxt   = '0;
        end
      end
      SAVE, RESTORE: begin
        idx_nxt = idx + ADDR_W'(1);
        if (last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i]     <= '0;
        shadow[i] <= '0;
      end
      acc        <= '0;
      shadow_acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (RF_we)  rf[wr_sel] <= data_in;
          if (Acc_we) acc        <= Acc_in;
        end
        SAVE: begin
          shadow[idx] <= rf[idx];
          if (last) shadow_acc <= acc;
        end
        RESTORE: begin
          rf[idx] <= shadow[idx];
          if (last) acc <= shadow_acc;
        end
        default: ;
      endcase
    end
  end

`ifdef RF_BYPASS_EN
  logic wr_live;
  assign wr_live    = (state == IDLE) && RF_we;
  assign data_out_a = (wr_live && (rd_sel_a == wr_sel)) ? data_in : rf[rd_sel_a];
  assign data_out_b = (wr_live && (rd_sel_b == wr_sel)) ? data_in : rf[rd_sel_b];
`else
  assign data_out_a = rf[rd_sel_a];
  assign data_out_b = rf[rd_sel_b];
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: writes, reads, save/restore, dropped writes, request priority, reset abort.
module tb_reg_bank;

  logic       reg_clk;
  logic       reg_rst;
  logic [1:0] wr_sel;
  logic       RF_we;
  logic [7:0] data_in;
  logic [1:0] rd_sel_a;
  logic [1:0] rd_sel_b;
  logic [7:0] data_out_a;
  logic [7:0] data_out_b;
  logic       Acc_we;
  logic [7:0] Acc_in;
  logic [7:0] Acc_out;
  logic       save_req;
  logic       restore_req;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  reg_bank #(.DATA_W(8), .ADDR_W(2)) dut (
    .reg_clk     (reg_clk),
    .reg_rst     (reg_rst),
    .wr_sel      (wr_sel),
    .RF_we       (RF_we),
    .data_in     (data_in),
    .rd_sel_a    (rd_sel_a),
    .rd_sel_b    (rd_sel_b),
    .data_out_a  (data_out_a),
    .data_out_b  (data_out_b),
    .Acc_we      (Acc_we),
    .Acc_in      (Acc_in),
    .Acc_out     (Acc_out),
    .save_req    (save_req),
    .restore_req (restore_req),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    reg_clk = 1'b0;
    forever #5 reg_clk = ~reg_clk;
  end

  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    wr_sel  = sel;
    data_in = d;
    RF_we   = 1'b1;
    tick();
    RF_we   = 1'b0;
  endtask

  task automatic wr_acc(input logic [7:0] d);
    Acc_in = d;
    Acc_we = 1'b1;
    tick();
    Acc_we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    rd_sel_a = sel;
    rd_sel_b = sel;
    #1;
    chk({tag, "_a"}, 32'(data_out_a), 32'(exp));
    chk({tag, "_b"}, 32'(data_out_b), 32'(exp));
  endtask

  task automatic chk_idle_done();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end",   32'(busy), 32'd0);
    tick();
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    reg_rst = 1'b0; wr_sel = '0; RF_we = 1'b0; data_in = '0;
    rd_sel_a = '0; rd_sel_b = '0; Acc_we = 1'b0; Acc_in = '0;
    save_req = 1'b0; restore_req = 1'b0;

    // Reset is asynchronous: outputs clear before any clock edge.
    #2 reg_rst = 1'b1;
    #1;
    chk("rst_out_a", 32'(data_out_a), 32'h0);
    chk("rst_out_b", 32'(data_out_b), 32'h0);
    chk("rst_acc",   32'(Acc_out),    32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_done",  32'(done),       32'h0);
    tick(); tick();
    reg_rst = 1'b0;

    // Basic writes, R3 and Acc in the same cycle.
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd2, 8'h33);
    Acc_in = 8'h5A; Acc_we = 1'b1;
    wr(2'd3, 8'h44);
    Acc_we = 1'b0;
    rd_sel_a = 2'd2; rd_sel_b = 2'd3;
    #1;
    chk("rd_a_r2", 32'(data_out_a), 32'h33);
    chk("rd_b_r3", 32'(data_out_b), 32'h44);
    chk("acc_5a",  32'(Acc_out),    32'h5A);
    chk_reg("rd_same_r0", 2'd0, 8'h11);

    // Same-cycle read of the register being written.
    rd_sel_a = 2'd2; wr_sel = 2'd2; data_in = 8'h77; RF_we = 1'b1;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_r2", 32'(data_out_a), 32'h77);
`else
    chk("bypass_r2", 32'(data_out_a), 32'h33);
`endif
    RF_we = 1'b0;
    #1;
    chk("no_write_r2", 32'(data_out_a), 32'h33);

    // Save with a write attempted on every busy cycle; it must be dropped.
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    wr_sel = 2'd1; data_in = 8'h99; RF_we = 1'b1;
    Acc_in = 8'hEE; Acc_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("save_busy", 32'(busy), 32'd1);
      chk("save_nodone", 32'(done), 32'd0);
      tick();
    end
    RF_we = 1'b0; Acc_we = 1'b0;
    rd_sel_a = 2'd1;
    #1;
    chk("dropped_wr_r1", 32'(data_out_a), 32'h22);
    chk("dropped_wr_acc", 32'(Acc_out), 32'h5A);
    chk_idle_done();

    // Trash the working context.
    for (int k = 0; k < 4; k++) wr(2'(k), 8'hFF);
    wr_acc(8'h00);
    chk_reg("trash_r1", 2'd1, 8'hFF);
    chk("trash_acc", 32'(Acc_out), 32'h00);

    // Restore: each register still holds old data until its own cycle's edge.
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_sel_a = 2'(k);
      #1;
      chk("rest_busy", 32'(busy), 32'd1);
      chk("rest_pending", 32'(data_out_a), 32'hFF);
      tick();
      chk("rest_landed", 32'(data_out_a), 32'((k + 1) * 8'h11));
    end
    chk("rest_acc", 32'(Acc_out), 32'h5A);
    chk_idle_done();
    chk_reg("rest_r0", 2'd0, 8'h11);
    chk_reg("rest_r3", 2'd3, 8'h44);

    // Simultaneous requests: save wins and R[] is untouched.
    wr(2'd0, 8'hA0);
    wr(2'd3, 8'hA3);
    wr_acc(8'h3C);
    save_req = 1'b1; restore_req = 1'b1;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("both_done", 32'(done), 32'd1);
    chk_reg("both_r0", 2'd0, 8'hA0);
    chk_reg("both_r3", 2'd3, 8'hA3);
    chk("both_acc", 32'(Acc_out), 32'h3C);
    tick();
    for (int k = 0; k < 4; k++) wr(2'(k), 8'h00);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_reg("shadow_r0", 2'd0, 8'hA0);
    chk_reg("shadow_r1", 2'd1, 8'h22);
    chk_reg("shadow_r3", 2'd3, 8'hA3);
    chk("shadow_acc", 32'(Acc_out), 32'h3C);
    tick();

    // Reset in the second cycle of a restore aborts it silently.
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reg_rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_acc",  32'(Acc_out), 32'h0);
    chk_reg("abort_r0", 2'd0, 8'h00);
    tick();
    reg_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      tick();
    end
    chk_reg("abort_r2", 2'd2, 8'h00);

    // First write after reset release takes effect at the next edge.
    wr(2'd1, 8'h05);
    chk_reg("post_rst_wr", 2'd1, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
